// File: rtl/pc_fetch_if.sv
`timescale 1ns/1ps
// Bundle between the fetch unit, instruction memory and the execute stage.
// Latency: none, this is wiring only.
// Backpressure: instr_waitrequest stalls reads and exec_done gates retirement.
interface pc_fetch_if;
    logic [31:0] pcnext;
    logic        redirect;
    logic        exec_done;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        active;
    logic        addr_error;

    // The fetch unit drives the memory request and the instruction it holds.
    modport master (
        input  pcnext, redirect, exec_done, instr_waitrequest, instr_readdata,
        output instr_read, instr_address, pc, instr, instr_valid, active, addr_error
    );

    // Memory and execute stage side.
    modport slave (
        output pcnext, redirect, exec_done, instr_waitrequest, instr_readdata,
        input  instr_read, instr_address, pc, instr, instr_valid, active, addr_error
    );
endinterface

// File: rtl/pc_fetch.sv
`timescale 1ns/1ps
// Fetch front end for a MIPS-style core with a single branch-delay slot.
// Latency: instr_valid one cycle after an accepted read; at most one instruction per two cycles.
// Backpressure: instr_waitrequest holds the read in FETCH; exec_done gates leaving EXEC.
module pc_fetch (
    input  logic       clk,
    input  logic       reset,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_dly_target;
    logic        r_dly_pending;
    logic        r_addr_error;

    logic [31:0] w_pc_new;
    logic        w_fetch_ack;
    logic        w_retire;
    logic        w_pc_zero;
    logic        w_pc_misaligned;
    logic        w_instr_read;
    logic        w_instr_valid;
    logic        w_active;

    // A pending branch target wins over sequential flow; the add wraps naturally at 2^32.
    assign w_pc_new        = r_dly_pending ? r_dly_target : (r_pc + 32'd4);
    assign w_pc_zero       = (w_pc_new == 32'h0000_0000);
    assign w_pc_misaligned = (w_pc_new[1:0] != 2'b00);
    assign w_fetch_ack     = (r_state == ST_FETCH) && !bus.instr_waitrequest;
    assign w_retire        = (r_state == ST_EXEC) && bus.exec_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; HALT is only left through reset
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_read  = 1'b0;
        w_instr_valid = 1'b0;
        w_active      = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_instr_read = 1'b1;
                w_active     = 1'b1;
                if (w_fetch_ack) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_instr_valid = 1'b1;
                w_active      = 1'b1;
                if (bus.exec_done) begin
                    w_state_nxt = (w_pc_zero || w_pc_misaligned) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // Latch the instruction word when memory accepts the read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= 32'h0000_0000;
        end else if (w_fetch_ack) begin
            r_instr <= bus.instr_readdata;
        end
    end

    // On retirement: advance pc, consume any pending target and arm a new one if this is a branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_dly_target  <= 32'h0000_0000;
            r_dly_pending <= 1'b0;
            r_addr_error  <= 1'b0;
        end else if (w_retire) begin
            r_pc          <= w_pc_new;
            r_dly_pending <= bus.redirect;
            if (bus.redirect) begin
                r_dly_target <= bus.pcnext;
            end
            if (w_pc_misaligned) begin
                r_addr_error <= 1'b1;
            end
        end
    end

    assign bus.instr_read    = w_instr_read;
    assign bus.instr_address = r_pc;
    assign bus.pc            = r_pc;
    assign bus.instr         = r_instr;
    assign bus.instr_valid   = w_instr_valid;
    assign bus.active        = w_active;
    assign bus.addr_error    = r_addr_error;
endmodule

// File: tb/tb_pc_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for pc_fetch: directed scenarios plus randomized programs
// compared against a queue-based model of the delay-slot rules.
// Memory and execute stage are emulated by stimulus tasks driving the interface.
module tb_pc_fetch;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pc_fetch_if io();

    pc_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        io.exec_done = 1'b0;
        io.redirect = 1'b0;
        io.instr_waitrequest = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for a read request, optionally stall it, then return the word.
    task automatic serve(input logic [31:0] data, input int waits,
                         output logic [31:0] addr, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        addr = 32'hxxxx_xxxx;
        io.instr_waitrequest = 1'b1;
        while (io.instr_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (io.instr_read !== 1'b1) return;
        addr = io.instr_address;
        repeat (waits) @(negedge clk);
        io.instr_waitrequest = 1'b0;
        io.instr_readdata = data;
        @(negedge clk);
        io.instr_waitrequest = 1'b1;
        io.instr_readdata = $urandom;
        ok = 1'b1;
    endtask

    // Retire the held instruction after some idle cycles of junk redirect/pcnext.
    task automatic exec_instr(input bit rd, input logic [31:0] tgt, input int idle);
        repeat (idle) begin
            io.exec_done = 1'b0;
            io.redirect = 1'($urandom_range(0, 1));
            io.pcnext = $urandom;
            @(negedge clk);
        end
        io.exec_done = 1'b1;
        io.redirect = rd;
        io.pcnext = tgt;
        @(negedge clk);
        io.exec_done = 1'b0;
        io.redirect = 1'($urandom_range(0, 1));
        io.pcnext = $urandom;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (io.pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", io.pc, RST_PC); end
        n_cmp++; if (io.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 00000000", io.instr); end
        n_cmp++; if (io.instr_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", io.instr_read); end
        n_cmp++; if (io.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", io.instr_valid); end
        n_cmp++; if (io.active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", io.active); end
        n_cmp++; if (io.addr_error !== 1'b0) begin n_err++; $display("FAIL reset_addr_error: got %b want 0", io.addr_error); end
        repeat (3) @(negedge clk);
        n_cmp++; if (io.instr_read !== 1'b0 || io.active !== 1'b0) begin n_err++; $display("FAIL reset_held: read %b active %b want 0 0", io.instr_read, io.active); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] a;
        bit ok;
        do_reset();
        serve(32'h2402_0005, 0, a, ok);
        n_cmp++; if (!ok || a !== RST_PC) begin n_err++; $display("FAIL basic_first_addr: got %h want %h", a, RST_PC); end
        n_cmp++; if (io.instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", io.instr_valid); end
        n_cmp++; if (io.instr !== 32'h2402_0005) begin n_err++; $display("FAIL basic_instr: got %h want 24020005", io.instr); end
        n_cmp++; if (io.pc !== RST_PC) begin n_err++; $display("FAIL basic_pc: got %h want %h", io.pc, RST_PC); end
        n_cmp++; if (io.instr_read !== 1'b0 || io.active !== 1'b1) begin n_err++; $display("FAIL basic_exec_outs: read %b active %b want 0 1", io.instr_read, io.active); end
        exec_instr(1'b0, 32'h0, 0);
        n_cmp++; if (io.instr_read !== 1'b1 || io.instr_address !== 32'hBFC0_0004) begin n_err++; $display("FAIL basic_next_addr: read %b addr %h want 1 bfc00004", io.instr_read, io.instr_address); end
        n_cmp++; if (io.instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_fetch_valid: got %b want 0", io.instr_valid); end
    endtask

    task automatic test_waitrequest();
        logic [31:0] a;
        bit ok;
        int n;
        do_reset();
        n = 0;
        while (io.instr_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        // exec_done/redirect while fetching must be ignored
        io.exec_done = 1'b1;
        io.redirect = 1'b1;
        io.pcnext = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (io.instr_read !== 1'b1 || io.instr_address !== RST_PC) begin n_err++; $display("FAIL wait_stable[%0d]: read %b addr %h want 1 %h", i, io.instr_read, io.instr_address, RST_PC); end
            n_cmp++; if (io.instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d]: got %b want 0", i, io.instr_valid); end
            if (i == 3) begin
                io.instr_waitrequest = 1'b0;
                io.instr_readdata = 32'h1234_5678;
            end
            @(negedge clk);
        end
        io.exec_done = 1'b0;
        io.redirect = 1'b0;
        io.instr_waitrequest = 1'b1;
        n_cmp++; if (io.instr_valid !== 1'b1 || io.instr !== 32'h1234_5678) begin n_err++; $display("FAIL wait_accept: valid %b instr %h want 1 12345678", io.instr_valid, io.instr); end
        exec_instr(1'b0, 32'h0, 2);
        serve($urandom, 1, a, ok);
        n_cmp++; if (!ok || a !== 32'hBFC0_0004) begin n_err++; $display("FAIL wait_next_addr: got %h want bfc00004", a); end
        exec_instr(1'b0, 32'h0, 0);
        n_cmp++; if (io.instr_address !== 32'hBFC0_0008 || io.active !== 1'b1) begin n_err++; $display("FAIL wait_no_pending: addr %h active %b want bfc00008 1", io.instr_address, io.active); end
    endtask

    task automatic test_branch_delay();
        logic [31:0] a;
        logic [31:0] want;
        bit ok;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            want = RST_PC + 32'(4 * k);
            serve($urandom, $urandom_range(0, 2), a, ok);
            n_cmp++; if (!ok || a !== want) begin n_err++; $display("FAIL branch_seq[%0d]: got %h want %h", k, a, want); end
            exec_instr(k == 4, 32'hBFC0_0100, $urandom_range(0, 2));
        end
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== 32'hBFC0_0014) begin n_err++; $display("FAIL branch_delay_slot: got %h want bfc00014", a); end
        exec_instr(1'b0, 32'h0, 0);
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== 32'hBFC0_0100) begin n_err++; $display("FAIL branch_target: got %h want bfc00100", a); end
        exec_instr(1'b0, 32'h0, 0);
        n_cmp++; if (io.instr_address !== 32'hBFC0_0104) begin n_err++; $display("FAIL branch_after_target: got %h want bfc00104", io.instr_address); end
    endtask

    task automatic test_jump_zero_halt();
        logic [31:0] a;
        bit ok;
        do_reset();
        serve($urandom, 0, a, ok);
        exec_instr(1'b1, 32'h0, 0);
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== 32'hBFC0_0004) begin n_err++; $display("FAIL zero_delay_slot: got %h want bfc00004", a); end
        exec_instr(1'b0, 32'h0, 0);
        io.instr_waitrequest = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (io.active !== 1'b0 || io.instr_read !== 1'b0 || io.instr_valid !== 1'b0) begin n_err++; $display("FAIL zero_halt[%0d]: active %b read %b valid %b want 0 0 0", i, io.active, io.instr_read, io.instr_valid); end
            n_cmp++; if (io.pc !== 32'h0 || io.addr_error !== 1'b0) begin n_err++; $display("FAIL zero_pc[%0d]: pc %h err %b want 00000000 0", i, io.pc, io.addr_error); end
            io.exec_done = 1'($urandom_range(0, 1));
            io.redirect = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        io.exec_done = 1'b0;
        io.instr_waitrequest = 1'b1;
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        bit ok;
        do_reset();
        serve($urandom, 0, a, ok);
        exec_instr(1'b1, 32'hBFC0_0102, 0);
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== 32'hBFC0_0004 || io.addr_error !== 1'b0) begin n_err++; $display("FAIL mis_delay_slot: addr %h err %b want bfc00004 0", a, io.addr_error); end
        exec_instr(1'b0, 32'h0, 0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (io.addr_error !== 1'b1 || io.active !== 1'b0 || io.instr_read !== 1'b0) begin n_err++; $display("FAIL mis_halt[%0d]: err %b active %b read %b want 1 0 0", i, io.addr_error, io.active, io.instr_read); end
            @(negedge clk);
        end
        n_cmp++; if (io.pc !== 32'hBFC0_0102) begin n_err++; $display("FAIL mis_pc: got %h want bfc00102", io.pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        do_reset();
        serve($urandom, 0, a, ok);
        exec_instr(1'b1, 32'hFFFF_FFFC, 0);
        serve($urandom, 0, a, ok);
        exec_instr(1'b0, 32'h0, 0);
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top_addr: got %h want fffffffc", a); end
        exec_instr(1'b0, 32'h0, 1);
        repeat (2) @(negedge clk);
        n_cmp++; if (io.pc !== 32'h0 || io.active !== 1'b0 || io.instr_read !== 1'b0 || io.addr_error !== 1'b0) begin n_err++; $display("FAIL wrap_halt: pc %h active %b read %b err %b want 00000000 0 0 0", io.pc, io.active, io.instr_read, io.addr_error); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] a;
        bit ok;
        do_reset();
        serve($urandom, 0, a, ok);
        exec_instr(1'b1, 32'hBFC0_0200, 0);
        repeat (2) @(negedge clk);
        n_cmp++; if (io.instr_read !== 1'b1 || io.instr_address !== 32'hBFC0_0004) begin n_err++; $display("FAIL rmid_pre: read %b addr %h want 1 bfc00004", io.instr_read, io.instr_address); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (io.instr_read !== 1'b0 || io.instr_valid !== 1'b0 || io.active !== 1'b0) begin n_err++; $display("FAIL rmid_async_outs: read %b valid %b active %b want 0 0 0", io.instr_read, io.instr_valid, io.active); end
        n_cmp++; if (io.pc !== RST_PC || io.instr_address !== RST_PC || io.instr !== 32'h0 || io.addr_error !== 1'b0) begin n_err++; $display("FAIL rmid_async_regs: pc %h addr %h instr %h err %b want bfc00000 bfc00000 00000000 0", io.pc, io.instr_address, io.instr, io.addr_error); end
        @(negedge clk);
        reset = 1'b0;
        serve($urandom, 0, a, ok);
        n_cmp++; if (!ok || a !== RST_PC) begin n_err++; $display("FAIL rmid_restart: got %h want %h", a, RST_PC); end
        exec_instr(1'b0, 32'h0, 0);
        serve($urandom, 0, a, ok);
        exec_instr(1'b0, 32'h0, 0);
        n_cmp++; if (!ok || a !== 32'hBFC0_0004 || io.instr_address !== 32'hBFC0_0008) begin n_err++; $display("FAIL rmid_no_pending: addrs %h %h want bfc00004 bfc00008", a, io.instr_address); end
    endtask

    // Random programs; the model keeps the delayed target in a queue.
    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] tgt;
        logic [31:0] nxt;
        logic [31:0] m_pc;
        logic [31:0] pend[$];
        bit ok;
        bit rd;
        bit m_err;
        bit halted;
        int sel;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            m_pc = RST_PC;
            pend.delete();
            m_err = 1'b0;
            halted = 1'b0;
            for (int k = 0; k < 40 && !halted; k++) begin
                d = $urandom;
                serve(d, $urandom_range(0, 3), a, ok);
                n_cmp++; if (!ok || a !== m_pc) begin n_err++; $display("FAIL rand_addr r%0d k%0d: got %h want %h", r, k, a, m_pc); end
                n_cmp++; if (io.instr !== d || io.instr_valid !== 1'b1 || io.pc !== m_pc) begin n_err++; $display("FAIL rand_exec r%0d k%0d: instr %h valid %b pc %h want %h 1 %h", r, k, io.instr, io.instr_valid, io.pc, d, m_pc); end
                rd = ($urandom_range(0, 3) == 0);
                sel = $urandom_range(0, 19);
                if (sel == 0) tgt = 32'h0;
                else if (sel == 1) tgt = {16'hBFC0, 14'($urandom), 2'($urandom_range(1, 3))};
                else if (sel == 2) tgt = 32'hFFFF_FFFC;
                else tgt = {16'hBFC0, 14'($urandom), 2'b00};
                exec_instr(rd, tgt, $urandom_range(0, 2));
                if (pend.size() != 0) nxt = pend.pop_front();
                else nxt = m_pc + 32'd4;
                if (rd) pend.push_back(tgt);
                m_pc = nxt;
                if (nxt == 32'h0) halted = 1'b1;
                else if (nxt[1:0] != 2'b00) begin halted = 1'b1; m_err = 1'b1; end
                n_cmp++; if (io.active !== (halted ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL rand_active r%0d k%0d: got %b want %b", r, k, io.active, !halted); end
            end
            n_cmp++; if (io.pc !== m_pc || io.addr_error !== m_err) begin n_err++; $display("FAIL rand_final r%0d: pc %h err %b want %h %b", r, io.pc, io.addr_error, m_pc, m_err); end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        n_cmp = 0;
        n_err = 0;
        io.pcnext = 32'h0;
        io.redirect = 1'b0;
        io.exec_done = 1'b0;
        io.instr_waitrequest = 1'b1;
        io.instr_readdata = 32'h0;
        test_reset();
        test_basic_fetch();
        test_waitrequest();
        test_branch_delay();
        test_jump_zero_halt();
        test_misaligned();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
